// File: rtl/multicycle_main_control.sv
// multicycle_main_control: multicycle FSM for RV32 LW/SW/BEQ/R-type.
// It drives the datapath enables and selects, and keeps a retire count and a sticky illegal-opcode flag.
module multicycle_main_control #(
    parameter logic [6:0] OPC_R   = 7'b0110011,
    parameter logic [6:0] OPC_LW  = 7'b0000011,
    parameter logic [6:0] OPC_SW  = 7'b0100011,
    parameter logic [6:0] OPC_BEQ = 7'b1100011,
    parameter int         CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             zero,
    output logic [1:0]       ALU_Op,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSource,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic [3:0]       state_out,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        TRAP      = 4'd10
    } state_t;

    state_t state, next_state;
    logic   retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            illegal_instr <= 1'b0;
            instr_count   <= '0;
        end else begin
            state <= next_state;
            if (next_state == TRAP)
                illegal_instr <= 1'b1;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:      next_state = FETCH;
            FETCH:     next_state = mem_ready ? DECODE : FETCH;
            DECODE:    next_state = (opcode == OPC_LW || opcode == OPC_SW) ? MEM_ADDR :
                                    (opcode == OPC_R)   ? EXECUTE :
                                    (opcode == OPC_BEQ) ? BRANCH : TRAP;
            MEM_ADDR:  next_state = (opcode == OPC_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  next_state = mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    next_state = FETCH;
            MEM_WRITE: next_state = mem_ready ? FETCH : MEM_WRITE;
            EXECUTE:   next_state = R_WB;
            R_WB:      next_state = FETCH;
            BRANCH:    next_state = FETCH;
            TRAP:      next_state = TRAP;
            default:   next_state = IDLE;
        endcase
    end

    // Every instruction completes by moving into FETCH from one of its final states.
    assign retire = (next_state == FETCH) && (state != IDLE) && (state != FETCH);
    assign state_out = state;

    always_comb begin
        ALU_Op   = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSource = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE:   ALUSrcB = 2'b10;
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALU_Op  = 2'b10;
            end
            R_WB:     RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALU_Op   = 2'b01;
                PCSource = 1'b1;
                PCWrite  = zero;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: directed and randomized instruction streams checked
// against a per-instruction expected state trace and control table.
module tb_multicycle_main_control;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'h0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic [1:0]  ALU_Op;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSource, RegWrite, MemtoReg;
    logic [3:0]  state_out;
    logic        illegal_instr;
    logic [31:0] instr_count;

    int passed = 0;
    int total = 0;
    logic [31:0] exp_count = 0;
    logic        exp_ill = 1'b0;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3;

    multicycle_main_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .ALU_Op(ALU_Op), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSource(PCSource), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .state_out(state_out), .illegal_instr(illegal_instr), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    wire [12:0] ctrl = {ALU_Op, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
                        IRWrite, PCWrite, PCSource, RegWrite, MemtoReg};

    // Control word required in each state, taken directly from the state descriptions.
    function automatic logic [12:0] exp_ctrl(input int st, input logic mr, input logic z);
        logic [1:0] aop, srcb;
        logic srca, iord, mrd, mwr, irw, pcw, pcs, rw, m2r;
        {aop, srcb} = 4'b0;
        {srca, iord, mrd, mwr, irw, pcw, pcs, rw, m2r} = 9'b0;
        case (st)
            1: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            2: srcb = 2'b10;
            3: begin srca = 1; srcb = 2'b10; end
            4: begin mrd = 1; iord = 1; end
            5: begin rw = 1; m2r = 1; end
            6: begin mwr = 1; iord = 1; end
            7: begin srca = 1; aop = 2'b10; end
            8: rw = 1;
            9: begin srca = 1; aop = 2'b01; pcs = 1; pcw = z; end
            default: ;
        endcase
        return {aop, srca, srcb, iord, mrd, mwr, irw, pcw, pcs, rw, m2r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // One clock: drive inputs, check at the falling edge, then advance past the rising edge.
    task automatic step(input int st, input logic mr, input logic z);
        mem_ready = mr;
        zero = z;
        @(negedge clk);
        chk("state", {28'b0, state_out}, st);
        chk("ctrl", {19'b0, ctrl}, {19'b0, exp_ctrl(st, mr, z)});
        chk("count", instr_count, exp_count);
        chk("illegal", {31'b0, illegal_instr}, {31'b0, exp_ill});
        chk("rd_wr_excl", {31'b0, MemRead & MemWrite}, 32'd0);
        chk("rw_wr_excl", {31'b0, RegWrite & MemWrite}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic fetch_decode(input int wf);
        for (int i = 0; i <= wf; i++) step(1, i == wf, rb());
        step(2, rb(), rb());
    endtask

    // wf/wm: cycles of mem_ready low in FETCH and in the memory-access state.
    task automatic run(input int kind, input int wf, input int wm, input logic z);
        case (kind)
            K_LW:  opcode = 7'b0000011;
            K_SW:  opcode = 7'b0100011;
            K_R:   opcode = 7'b0110011;
            default: opcode = 7'b1100011;
        endcase
        fetch_decode(wf);
        case (kind)
            K_LW: begin
                step(3, rb(), rb());
                for (int i = 0; i <= wm; i++) step(4, i == wm, rb());
                step(5, rb(), rb());
            end
            K_SW: begin
                step(3, rb(), rb());
                for (int i = 0; i <= wm; i++) step(6, i == wm, rb());
            end
            K_R: begin
                step(7, rb(), rb());
                step(8, rb(), rb());
            end
            default: step(9, rb(), z);
        endcase
        exp_count++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {28'b0, state_out}, 32'd0);
        chk("reset_ctrl", {19'b0, ctrl}, 32'd0);
        chk("reset_count", instr_count, 32'd0);
        chk("reset_illegal", {31'b0, illegal_instr}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 1'b1, 1'b1);

        run(K_R, 0, 0, 1'b0);
        run(K_LW, 0, 2, 1'b0);
        run(K_BEQ, 0, 0, 1'b1);
        run(K_BEQ, 0, 0, 1'b0);
        run(K_SW, 1, 1, 1'b0);

        for (int n = 0; n < 40; n++)
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), rb());

        // Asynchronous reset while a store waits on memory.
        opcode = 7'b0100011;
        fetch_decode(0);
        step(3, 1'b0, 1'b0);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("memwrite_pending", {31'b0, MemWrite}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_count = 0;
        chk("abort_memwrite", {31'b0, MemWrite}, 32'd0);
        chk("abort_state", {28'b0, state_out}, 32'd0);
        chk("abort_count", instr_count, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, rb(), rb());
        run(K_LW, 0, 0, 1'b0);
        run(K_R, 2, 0, 1'b0);

        // Illegal opcode traps permanently without retiring.
        opcode = 7'b1111111;
        fetch_decode(0);
        exp_ill = 1'b1;
        for (int i = 0; i < 20; i++) step(10, rb(), rb());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle main control FSM for the RV32 subset LW, SW, BEQ and R-type (ADD/SUB/AND/OR).
- Produces the ALU_Op code consumed by the ALU control decoder, together with the datapath enables and selects.
- Sits between the instruction register (opcode) and the datapath.
- Also handles the memory-ready handshake, a retired-instruction count and sticky illegal-opcode detection.

Parameters:
- OPC_R, 7'b0110011, R-type opcode
- OPC_LW, 7'b0000011, load word opcode
- OPC_SW, 7'b0100011, store word opcode
- OPC_BEQ, 7'b1100011, branch-equal opcode
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instruction[6:0] from the instruction register; stable after the FETCH write
- mem_ready  input  1  memory has completed the current read/write this cycle
- zero  input  1  ALU zero flag
- ALU_Op  output  2  00 = add, 01 = subtract (branch), 10 = R-type decode by fun7/fun3
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = immediate
- IorD  output  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load instruction register
- PCWrite  output  1  load PC
- PCSource  output  1  0 = ALU result, 1 = ALUOut (branch target)
- RegWrite  output  1  register file write
- MemtoReg  output  1  write-back data: 0 = ALUOut, 1 = memory data register
- state_out  output  4  current state encoding
- illegal_instr  output  1  sticky illegal-opcode flag
- instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, instr_count = 0, illegal_instr = 0.
- All outputs are 0 in IDLE, including ALU_Op = 00 and ALUSrcB = 00.
- Reset mid-operation aborts immediately; no partial write is completed.
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_READ = 4, MEM_WB = 5, MEM_WRITE = 6, EXECUTE = 7, R_WB = 8, BRANCH = 9, TRAP = 10.
- Unused encodings go to IDLE on the next clock.
- Outputs are decoded combinationally from state. Only IRWrite/PCWrite in FETCH and PCWrite in BRANCH also depend on inputs. Any unlisted output is 0.
- IDLE: go to FETCH on the first clock with rst_n high.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALU_Op = 00, PCSource = 0.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when it is 1.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 10, ALU_Op = 00 (branch target into ALUOut).
  - Next state: LW/SW → MEM_ADDR, R → EXECUTE, BEQ → BRANCH, any other opcode → TRAP.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALU_Op = 00. Next state is MEM_READ if opcode = OPC_LW, else MEM_WRITE.
- MEM_READ: MemRead = 1, IorD = 1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1. Go to FETCH and retire.
- MEM_WRITE: MemWrite = 1, IorD = 1. Wait for mem_ready, then go to FETCH and retire.
- EXECUTE: ALUSrcA = 1, ALUSrcB = 00, ALU_Op = 10. Go to R_WB.
- R_WB: RegWrite = 1, MemtoReg = 0. Go to FETCH and retire.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 00, ALU_Op = 01, PCSource = 1, PCWrite = zero.
  - Go to FETCH and retire regardless of zero.
- TRAP: illegal_instr is set on entry and held. Absorbing state; only reset exits. All enables are 0.
- Retire: instr_count increments by 1 on the clock leaving MEM_WB, MEM_WRITE, R_WB or BRANCH. It wraps from all-ones to 0. Never increments for TRAP.
- Cycles per instruction with mem_ready = 1: LW 5, SW 4, R-type 4, BEQ 3. Each cycle of mem_ready = 0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_ready is ignored in all other states.
- MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.

Test Plan:
- Reset: hold rst_n = 0 → all outputs 0, state_out = 0. Release → state_out 1 next cycle with MemRead = 1, ALUSrcB = 01.
- R-type (opcode 0110011, mem_ready = 1):
  - state_out sequence 1, 2, 7, 8, 1.
  - ALU_Op = 10 only in state 7; RegWrite = 1 only in state 8.
  - instr_count goes 0 → 1.
- LW with mem_ready low 2 cycles in MEM_READ:
  - sequence 1, 2, 3, 4, 4, 4, 5, 1 (8 cycles).
  - IorD = 1 in state 4; MemtoReg = RegWrite = 1 in state 5.
- BEQ:
  - zero = 1 → PCWrite = 1, PCSource = 1, ALU_Op = 01 in state 9.
  - zero = 0 → PCWrite = 0.
  - Both cases retire (count +1).
- Illegal opcode 1111111 → state 10 after DECODE; illegal_instr = 1 and stays for 20 cycles. instr_count unchanged, all write enables 0.
- Reset asserted during MEM_WRITE with mem_ready = 0:
  - MemWrite drops to 0 immediately, state_out = 0, instr_count = 0.
  - After release, normal fetch resumes.
